// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per clock, full schedule held.
// Ports: clk, rst_n, start_i, key_i -> busy_o, done_o, keys_valid_o, round_key_o[0:10].
// Optional macro AES_KEY_EXPAND_ZEROIZE_EN adds zeroize_i (clears all key state).
module aes_key_expand #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef AES_KEY_EXPAND_ZEROIZE_EN
  input  logic         zeroize_i,
`endif
  input  logic         start_i,
  input  logic [127:0] key_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         keys_valid_o,
  output logic [127:0] round_key_o [0:NUM_ROUNDS]
);

  if (NUM_ROUNDS != 10) begin : g_bad_rounds
    $error("aes_key_expand: NUM_ROUNDS must be 10");
  end

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_EXPAND = 1'b1;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  logic [0:0]   state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         done_q, done_d;
  logic         valid_q, valid_d;
  logic [127:0] rk_q [0:NUM_ROUNDS];
  logic [127:0] rk_d [0:NUM_ROUNDS];

  logic [3:0]   prev_idx;
  logic [127:0] prev;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot, sub, t;
  logic [31:0]  n0, n1, n2, n3;
  logic [7:0]   rcon;
  logic         zeroize;

`ifdef AES_KEY_EXPAND_ZEROIZE_EN
  assign zeroize = zeroize_i;
`else
  assign zeroize = 1'b0;
`endif

  // Previous round key selected with a compare mux so that the
  // IDLE value cnt_q==0 never forms an out-of-range index.
  assign prev_idx = cnt_q - 4'd1;

  always_comb begin
    prev = '0;
    for (int i = 0; i <= NUM_ROUNDS; i++) begin
      if (prev_idx == 4'(i)) prev = rk_q[i];
    end
  end

  always_comb begin
    rcon = 8'h00;
    case (cnt_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign w0  = prev[127:96];
  assign w1  = prev[95:64];
  assign w2  = prev[63:32];
  assign w3  = prev[31:0];
  assign rot = {w3[23:0], w3[31:24]};

  assign sub = {SBOX[rot[31:24]], SBOX[rot[23:16]],
                SBOX[rot[15:8]],  SBOX[rot[7:0]]};

  assign t  = sub ^ {rcon, 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    rk_d    = rk_q;
    if (zeroize) begin
      state_d = S_IDLE;
      cnt_d   = 4'd0;
      valid_d = 1'b0;
      for (int i = 0; i <= NUM_ROUNDS; i++) rk_d[i] = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            rk_d[0] = key_i;
            cnt_d   = 4'd1;
            valid_d = 1'b0;
            state_d = S_EXPAND;
          end
        end
        S_EXPAND: begin
          for (int i = 1; i <= NUM_ROUNDS; i++) begin
            if (cnt_q == 4'(i)) rk_d[i] = {n0, n1, n2, n3};
          end
          if (cnt_q == 4'(NUM_ROUNDS)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      for (int i = 0; i <= NUM_ROUNDS; i++) rk_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      for (int i = 0; i <= NUM_ROUNDS; i++) rk_q[i] <= rk_d[i];
    end
  end

  assign busy_o       = (state_q == S_EXPAND);
  assign done_o       = done_q;
  assign keys_valid_o = valid_q;
  assign round_key_o  = rk_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: FIPS-197 vectors, random keys vs a GF(2^8) model,
// and hand sequences for hold-start, mid-run reset, back-to-back and zeroize.
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_i;
  logic [127:0] key_i;
  logic         busy_o, done_o, keys_valid_o;
  logic [127:0] rk [0:10];
`ifdef AES_KEY_EXPAND_ZEROIZE_EN
  logic         zeroize_i;
`endif

  aes_key_expand #(.NUM_ROUNDS(10)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef AES_KEY_EXPAND_ZEROIZE_EN
    .zeroize_i    (zeroize_i),
`endif
    .start_i      (start_i),
    .key_i        (key_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .keys_valid_o (keys_valid_o),
    .round_key_o  (rk)
  );

  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Reference model: S-box from GF(2^8) inverse and affine map.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic       hi;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] x);
    if (x == 8'h00) return 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (gmul(x, 8'(y)) == 8'h01) return 8'(y);
    end
    return 8'h00;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] msbox(input logic [7:0] x);
    logic [7:0] b = ginv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  logic [127:0] model [0:10];

  task automatic expand_model(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {msbox(tmp[31:24]), msbox(tmp[23:16]),
               msbox(tmp[15:8]), msbox(tmp[7:0])};
        tmp = tmp ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r <= 10; r++)
      model[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk_sched(input string nm, input logic [127:0] k);
    expand_model(k);
    for (int r = 0; r <= 10; r++)
      chk($sformatf("%s rk%0d", nm, r), rk[r], model[r]);
  endtask

  task automatic chk_all_zero(input string nm);
    logic [127:0] acc = '0;
    for (int r = 0; r <= 10; r++) acc = acc | rk[r];
    chk({nm, " keys"}, acc, '0);
    chk({nm, " busy"}, 128'(busy_o), 0);
    chk({nm, " done"}, 128'(done_o), 0);
    chk({nm, " valid"}, 128'(keys_valid_o), 0);
  endtask

  task automatic start_key(input string nm, input logic [127:0] k);
    @(negedge clk);
    key_i   = k;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    key_i   = {$urandom, $urandom, $urandom, $urandom};
    chk({nm, " acc rk0"}, rk[0], k);
    chk({nm, " acc busy"}, 128'(busy_o), 1);
    chk({nm, " acc valid"}, 128'(keys_valid_o), 0);
  endtask

  // Called 1ns after the acceptance edge; returns 1ns after the done edge.
  task automatic wait_done(input string nm);
    int n = 0;
    int b = 0;
    while (!done_o && n < 30) begin
      if (busy_o) b++;
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, " latency"}, 128'(n), 10);
    chk({nm, " busy cycles"}, 128'(b), 10);
    chk({nm, " valid at done"}, 128'(keys_valid_o), 1);
    chk({nm, " busy at done"}, 128'(busy_o), 0);
  endtask

  typedef struct {
    string        name;
    logic [127:0] key;
    logic [127:0] rk1;
    logic [127:0] rk10;
  } vec_t;

  vec_t vecs [2];

  initial begin
    logic [127:0] ka, kb, ones;
    vecs[0] = '{"fips", 128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'ha0fafe1788542cb123a339392a6c7605,
                128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[1] = '{"zero", 128'h0,
                128'h62636363626363636263636362636363,
                128'hb4ef5bcb3e92e21123e951cf6f8f188e};
    ones = '1;

    rst_n   = 1'b0;
    start_i = 1'b0;
    key_i   = '0;
`ifdef AES_KEY_EXPAND_ZEROIZE_EN
    zeroize_i = 1'b0;
`endif
    #1;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all_zero("idle hold");

    // Golden vectors, then check the done pulse is one cycle wide.
    for (int v = 0; v < 2; v++) begin
      start_key(vecs[v].name, vecs[v].key);
      wait_done(vecs[v].name);
      chk({vecs[v].name, " rk1"}, rk[1], vecs[v].rk1);
      chk({vecs[v].name, " rk10"}, rk[10], vecs[v].rk10);
      chk_sched(vecs[v].name, vecs[v].key);
      @(posedge clk);
      #1;
      chk({vecs[v].name, " done width"}, 128'(done_o), 0);
      chk({vecs[v].name, " valid hold"}, 128'(keys_valid_o), 1);
      chk({vecs[v].name, " rk10 hold"}, rk[10], vecs[v].rk10);
    end

    // Random keys against the model.
    for (int i = 0; i < 4; i++) begin
      ka = {$urandom, $urandom, $urandom, $urandom};
      start_key($sformatf("rnd%0d", i), ka);
      wait_done($sformatf("rnd%0d", i));
      chk_sched($sformatf("rnd%0d", i), ka);
    end

    // start_i held high; key changes after acceptance.
    ka = vecs[0].key;
    @(negedge clk);
    key_i   = ka;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    key_i = ones;
    wait_done("hold");
    chk_sched("hold", ka);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    chk("hold reacc rk0", rk[0], ones);
    chk("hold reacc valid", 128'(keys_valid_o), 0);
    chk("hold reacc busy", 128'(busy_o), 1);
    wait_done("hold2");
    chk_sched("hold2", ones);

    // Reset in the middle of an expansion.
    start_key("mid", vecs[0].key);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    start_key("post", vecs[0].key);
    wait_done("post");
    chk("post rk10", rk[10], vecs[0].rk10);
    chk_sched("post", vecs[0].key);

    // Back-to-back: B accepted on the edge where A's done is high.
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = {$urandom, $urandom, $urandom, $urandom};
    start_key("b2bA", ka);
    wait_done("b2bA");
    chk_sched("b2bA", ka);
    start_key("b2bB", kb);
    wait_done("b2bB");
    chk_sched("b2bB", kb);

`ifdef AES_KEY_EXPAND_ZEROIZE_EN
    begin
      int seen = 0;
      start_key("zer", vecs[0].key);
      repeat (2) @(posedge clk);
      @(negedge clk);
      zeroize_i = 1'b1;
      start_i   = 1'b1;
      @(posedge clk);
      #1;
      zeroize_i = 1'b0;
      start_i   = 1'b0;
      chk_all_zero("zeroize");
      for (int c = 0; c < 12; c++) begin
        @(posedge clk);
        #1;
        if (done_o) seen++;
      end
      chk("zeroize no done", 128'(seen), 0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
- Iterative AES-128 key schedule; the stage directly upstream of the aes pipeline.
- Takes a 128-bit cipher key and produces the 11 round keys that drive the aes round_key_i array.
- Computes one round key per clock. Holds the full schedule stable in registers until the next start.

Parameters:
- NUM_ROUNDS, 10, number of rounds. Only 10 (AES-128) is legal; any other value fails elaboration.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start_i  input  1  request expansion of key_i; sampled only in IDLE.
- key_i  input  128  cipher key, byte 0 in bits [127:120]; sampled in the start-acceptance cycle only.
- busy_o  output  1  high while in EXPAND.
- done_o  output  1  one-cycle pulse when round key 10 has been written.
- keys_valid_o  output  1  level; the complete schedule is valid and stable.
- round_key_o  output  128 x [10:0]  unpacked array; index 0 is the cipher key; connects directly to aes round_key_i.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state=IDLE, round counter=0.
  - busy_o=0, done_o=0, keys_valid_o=0.
  - All 11 round_key_o entries = 0.
  - Applies immediately, including mid-expansion; a partial schedule is discarded.
- FSM states: IDLE, EXPAND.
- IDLE with start_i=1 at a rising edge (acceptance edge):
  - round_key_o[0] <= key_i, counter <= 1, keys_valid_o <= 0, state <= EXPAND.
- IDLE with start_i=0: all registers hold.
- EXPAND, each edge:
  - Let prev = round_key_o[counter-1], split into words w0..w3 (w0 = bits [127:96]).
  - t = SubWord(RotWord(w3)) XOR {rcon[counter], 24'h0}.
  - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2.
  - round_key_o[counter] <= {n0,n1,n2,n3}; counter <= counter+1.
- rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36, from a 10-entry constant table (no GF doubling logic).
- SubWord uses four parallel combinational copies of the standard AES S-box.
- Finishing: when counter==10 the write completes, then state <= IDLE, done_o <= 1 for exactly one cycle, keys_valid_o <= 1.
- Latency: done_o and keys_valid_o rise 10 cycles after the acceptance edge; busy_o is high for exactly 10 cycles.
- start_i while busy_o=1 is ignored, with no queuing.
- start_i in the same cycle that done_o is high is accepted; keys_valid_o returns to 0 on that edge.
- Re-key: round_key_o[1..10] hold their old values until overwritten in sequence. Consumers must gate on keys_valid_o.
- round_key_o entries change only on the acceptance edge or in EXPAND; they never glitch while keys_valid_o=1.
- Counter width is 4 bits; it never exceeds 10 and does not wrap.

Optional Feature:
- Macro: AES_KEY_EXPAND_ZEROIZE_EN.
- Defined:
  - Adds input port zeroize_i (1 bit).
  - On a rising edge with zeroize_i=1, all round keys become 0, keys_valid_o=0, busy_o=0, state=IDLE.
  - zeroize_i has priority over start_i and over an in-progress expansion.
  - done_o is not pulsed for an aborted expansion.
- Undefined: the port does not exist; key material is cleared only by rst_n.

Test Plan:
- FIPS-197 A.1: key_i=2b7e151628aed2a6abf7158809cf4f3c with a 1-cycle start_i pulse.
  - round_key_o[1]=a0fafe1788542cb123a339392a6c7605.
  - round_key_o[10]=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - done_o high exactly 10 cycles after the acceptance edge, for 1 cycle; busy_o high for 10 cycles.
- All-zero key:
  - round_key_o[1]=62636363626363636263636362636363.
  - round_key_o[10]=b4ef5bcb3e92e21123e951cf6f8f188e.
- start_i held high through expansion with key_i changed to ffff...ff after acceptance:
  - The schedule still matches the originally accepted key.
  - The next expansion starts on the edge where done_o=1.
- rst_n pulsed low at cycle 5 of an expansion:
  - All outputs are immediately 0.
  - A fresh start afterwards reproduces the FIPS-197 schedule.
- Back-to-back keys A then B: keys_valid_o drops on B's acceptance edge and rises 10 cycles later with the B schedule. Connected to aes, ciphertexts match golden data for both keys.
- With AES_KEY_EXPAND_ZEROIZE_EN: zeroize_i at cycle 3 of an expansion -> all round_key_o=0, busy_o=0, no done_o pulse.
